// File: rtl/vjtag_mem_bridge.sv
// Virtual JTAG DR-chain consumer: oversamples the hub signals in the system clock
// domain and turns ADDR/WDATA/RDATA updates into single-beat memory requests.
module vjtag_mem_bridge #(
    parameter int IR_WIDTH    = 24,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tck,
    input  logic                  tdi,
    output logic                  tdo,
    input  logic [IR_WIDTH-1:0]   ir_in,
    output logic [IR_WIDTH-1:0]   ir_out,
    input  logic                  virtual_state_cdr,
    input  logic                  virtual_state_sdr,
    input  logic                  virtual_state_udr,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [3:0] IR_ADDR   = 4'd1;
    localparam logic [3:0] IR_WDATA  = 4'd2;
    localparam logic [3:0] IR_RDATA  = 4'd3;
    localparam logic [3:0] IR_STATUS = 4'd4;

    localparam int SR_W0 = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int SR_W  = (SR_W0 > 8) ? SR_W0 : 8;
    localparam int SR_IW = $clog2(SR_W);

    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic                        tck_prev;
    logic                        tck_s, tdi_s, cdr_s, sdr_s, udr_s, tck_rise;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rbuf;
    logic                  overflow;
    logic [SR_W-1:0]       sr, sr_shift, cap_val, mask;
    logic [SR_IW-1:0]      len_m1;
    logic [7:0]            status;
    logic [3:0]            ir_op;
    logic                  unused_ir;

    assign {tck_s, tdi_s, cdr_s, sdr_s, udr_s} = sync_q[SYNC_STAGES-1];
    assign tck_rise  = tck_s & ~tck_prev;
    assign ir_op     = ir_in[3:0];
    assign unused_ir = ^ir_in[IR_WIDTH-1:4];

    assign status       = {5'b0, overflow, state == S_WAIT, mem_req_valid};
    assign ir_out       = {{(IR_WIDTH-8){1'b0}}, status};
    assign tdo          = sr[0];
    assign mem_req_addr = addr;

    // Chain length and capture value for the selected instruction; BYPASS is one bit wide.
    always_comb begin
        len_m1  = '0;
        cap_val = '0;
        case (ir_op)
            IR_ADDR: begin
                len_m1                   = SR_IW'(ADDR_WIDTH - 1);
                cap_val[ADDR_WIDTH-1:0]  = addr;
            end
            IR_WDATA:  len_m1 = SR_IW'(DATA_WIDTH - 1);
            IR_RDATA: begin
                len_m1                   = SR_IW'(DATA_WIDTH - 1);
                cap_val[DATA_WIDTH-1:0]  = rbuf;
            end
            IR_STATUS: begin
                len_m1       = SR_IW'(7);
                cap_val[7:0] = status;
            end
            default: ;
        endcase
    end

    always_comb begin
        mask             = ~({SR_W{1'b1}} << len_m1);
        sr_shift         = (sr >> 1) & mask;
        sr_shift[len_m1] = tdi_s;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            tck_prev <= 1'b0;
        end else begin
            sync_q[0] <= {tck, tdi, virtual_state_cdr, virtual_state_sdr, virtual_state_udr};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            tck_prev <= tck_s;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            addr          <= '0;
            rbuf          <= '0;
            overflow      <= 1'b0;
            sr            <= '0;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_req_wdata <= '0;
        end else begin
            // JTAG side: UDR launches only from IDLE, so it never collides with the FSM below.
            if (tck_rise) begin
                if (cdr_s) begin
                    sr <= cap_val;
                    if (ir_op == IR_STATUS) overflow <= 1'b0;
                end else if (sdr_s) begin
                    sr <= sr_shift;
                end else if (udr_s && (ir_op == IR_ADDR || ir_op == IR_WDATA || ir_op == IR_RDATA)) begin
                    if (state != S_IDLE) begin
                        overflow <= 1'b1;
                    end else if (ir_op == IR_ADDR) begin
                        addr <= sr[ADDR_WIDTH-1:0];
                    end else begin
                        state         <= S_REQ;
                        mem_req_valid <= 1'b1;
                        mem_req_write <= (ir_op == IR_WDATA);
                        if (ir_op == IR_WDATA) mem_req_wdata <= sr[DATA_WIDTH-1:0];
                    end
                end
            end

            case (state)
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (mem_req_write) begin
                            state <= S_IDLE;
                            addr  <= addr + 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        rbuf  <= mem_resp_rdata;
                        addr  <= addr + 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vjtag_mem_bridge.sv
// Directed bench for vjtag_mem_bridge: JTAG scans drive the bridge, a memory model
// answers requests, and a monitor checks each handshake against queued expectations.
module tb_vjtag_mem_bridge;
    logic        clock = 0, reset = 1;
    logic        tck = 0, tdi = 0, tdo;
    logic [23:0] ir_in = '0, ir_out;
    logic        cdr = 0, sdr = 0, udr = 0;
    logic        mem_req_valid, mem_req_ready = 0, mem_req_write;
    logic [15:0] mem_req_addr;
    logic [7:0]  mem_req_wdata, mem_resp_rdata = '0;
    logic        mem_resp_valid = 0;

    vjtag_mem_bridge dut (
        .clock(clock), .reset(reset), .tck(tck), .tdi(tdi), .tdo(tdo),
        .ir_in(ir_in), .ir_out(ir_out),
        .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_udr(udr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata)
    );

    always #5 clock = ~clock;

    int passed = 0, total = 0;
    logic [24:0] exp_q[$];   // {write, addr, wdata}
    int vcyc = 0, last_vcyc = 0;
    int ready_delay = 0, resp_delay = 0;
    logic [7:0] resp_data = '0;
    bit hold_ready = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Memory model: ready after ready_delay cycles of valid, read data resp_delay cycles after accept.
    initial begin
        int cnt = 0, rcnt = 0;
        bit pend = 0, last_write = 0;
        forever begin
            @(negedge clock);
            if (mem_resp_valid) mem_resp_valid = 0;
            if (reset) begin
                mem_req_ready = 0; cnt = 0; pend = 0;
            end else if (mem_req_ready) begin
                mem_req_ready = 0; cnt = 0;
                if (!last_write) begin pend = 1; rcnt = 0; end
            end else if (mem_req_valid && !hold_ready) begin
                if (cnt >= ready_delay) begin mem_req_ready = 1; last_write = mem_req_write; end
                else cnt++;
            end
            if (pend) begin
                rcnt++;
                if (rcnt >= resp_delay) begin
                    mem_resp_valid = 1; mem_resp_rdata = resp_data; pend = 0;
                end
            end
        end
    end

    // Monitor: a handshake is due at the next posedge when valid&ready are both up here.
    initial begin
        logic [24:0] e;
        forever begin
            @(negedge clock); #2;
            if (reset) vcyc = 0;
            else begin
                if (mem_req_valid) vcyc++;
                if (mem_req_valid && mem_req_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_req", {7'b0, mem_req_write, mem_req_addr, mem_req_wdata}, 32'hFFFF_FFFF);
                    else begin
                        e = exp_q.pop_front();
                        chk("req", {7'b0, mem_req_write, mem_req_addr, mem_req_write ? mem_req_wdata : 8'h00}, {7'b0, e});
                    end
                    last_vcyc = vcyc; vcyc = 0;
                end
            end
        end
    end

    task automatic tck_pulse();
        #50 tck = 1;
        #50 tck = 0;
    endtask

    task automatic jtag_dr(input logic [3:0] ir, input int len, input logic [15:0] din,
                           input bit do_udr, output logic [15:0] dout);
        ir_in = {20'b0, ir};
        dout  = '0;
        cdr = 1; tck_pulse(); cdr = 0;
        sdr = 1;
        for (int i = 0; i < len; i++) begin
            tdi = din[i];
            #50 dout[i] = tdo;
            tck = 1;
            #50 tck = 0;
        end
        sdr = 0; tdi = 0;
        if (do_udr) begin udr = 1; tck_pulse(); udr = 0; end
        #100;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || mem_req_valid || ir_out[1]) && n < 1000) begin
            @(negedge clock); n++;
        end
        if (n >= 1000) chk({name, "_timeout"}, 32'(n), 32'd0);
        #20;
    endtask

    logic [15:0] d;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #25 reset = 0;
        #40;

        // 1: reset while a write is pending
        hold_ready = 1;
        jtag_dr(4'h1, 16, 16'h0042, 1, d);
        jtag_dr(4'h2, 8, 16'h0077, 1, d);
        chk("t1_valid_before", 32'(mem_req_valid), 32'd1);
        @(negedge clock) reset = 1;
        @(negedge clock);
        chk("t1_valid", 32'(mem_req_valid), 32'd0);
        chk("t1_tdo", 32'(tdo), 32'd0);
        chk("t1_ir_out", 32'(ir_out), 32'd0);
        reset = 0; hold_ready = 0;
        #40;
        jtag_dr(4'h4, 8, 16'h0, 0, d);
        chk("t1_status", 32'(d), 32'h00);
        jtag_dr(4'h1, 16, 16'h0, 0, d);
        chk("t1_addr", 32'(d), 32'h0000);

        // 2: write with ready delayed 3 clocks
        ready_delay = 3;
        exp_q.push_back({1'b1, 16'h1234, 8'hA5});
        jtag_dr(4'h1, 16, 16'h1234, 1, d);
        jtag_dr(4'h2, 8, 16'h00A5, 1, d);
        wait_idle("t2");
        chk("t2_valid_cycles", 32'(last_vcyc), 32'd4);
        jtag_dr(4'h1, 16, 16'h0, 0, d);
        chk("t2_addr", 32'(d), 32'h1235);

        // 3: read, response after 5 clocks
        ready_delay = 0; resp_delay = 5; resp_data = 8'h3C;
        exp_q.push_back({1'b0, 16'h00FF, 8'h00});
        jtag_dr(4'h1, 16, 16'h00FF, 1, d);
        jtag_dr(4'h3, 8, 16'h0, 1, d);
        wait_idle("t3");
        jtag_dr(4'h3, 8, 16'h0, 0, d);
        chk("t3_rdata", 32'(d), 32'h3C);
        jtag_dr(4'h1, 16, 16'h0, 0, d);
        chk("t3_addr", 32'(d), 32'h0100);

        // 4: address wrap
        exp_q.push_back({1'b1, 16'hFFFF, 8'h11});
        jtag_dr(4'h1, 16, 16'hFFFF, 1, d);
        jtag_dr(4'h2, 8, 16'h0011, 1, d);
        wait_idle("t4");
        jtag_dr(4'h1, 16, 16'h0, 0, d);
        chk("t4_addr_wrap", 32'(d), 32'h0000);

        // 5: second WDATA while stalled -> overflow, single request
        hold_ready = 1;
        jtag_dr(4'h1, 16, 16'h0200, 1, d);
        exp_q.push_back({1'b1, 16'h0200, 8'h5A});
        jtag_dr(4'h2, 8, 16'h005A, 1, d);
        jtag_dr(4'h2, 8, 16'h0066, 1, d);
        jtag_dr(4'h4, 8, 16'h0, 0, d);
        chk("t5_status_ovf", 32'(d), 32'h05);
        jtag_dr(4'h4, 8, 16'h0, 0, d);
        chk("t5_status_clr", 32'(d), 32'h01);
        hold_ready = 0;
        wait_idle("t5");
        jtag_dr(4'h1, 16, 16'h0, 0, d);
        chk("t5_addr", 32'(d), 32'h0201);

        // 6: bypass delays tdi by one tck, no memory traffic
        jtag_dr(4'h7, 8, 16'h00B2, 1, d);
        chk("t6_bypass", 32'(d), 32'h64);
        repeat (20) @(negedge clock);
        chk("t6_ir_out", 32'(ir_out), 32'h00);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
